dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, log2 of storage depth in 32-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2, access wait states inserted before the response, range 0..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 ce_i  input  1  chip enable from the MEM stage; request present while high.
REQ-006 we_i  input  1  1 = write, 0 = read; valid while ce_i is high.
REQ-007 sel_i  input  4  byte-lane enables; bit n covers data bits [8n+7:8n].
REQ-008 addr_i  input  32  byte address.
REQ-009 data_i  input  32  store data.
REQ-010 data_o  output  32  load data; valid only while ack_o is high.
REQ-011 ack_o  output  1  access complete this cycle.
REQ-012 stall_req_o  output  1  pipeline hold request to the stall controller.
REQ-013 err_o  output  1  misaligned-access flag, qualified by ack_o.

Function
REQ-014 FSM states: IDLE, WAIT, RESP; one outstanding access at a time.
REQ-015 IDLE with ce_i=1: latch addr/we/sel/data; go to WAIT with counter=WAIT_CYCLES, or go straight to RESP when WAIT_CYCLES=0.
REQ-016 WAIT: decrement the counter each cycle; go to RESP on the edge where the counter reaches 0.
REQ-017 WAIT with ce_i=0 (pipeline flush on exception): abort to IDLE next edge; no write; no ack_o.
REQ-018 RESP lasts exactly one cycle, then IDLE; ce_i sampled in RESP is not accepted as a new request.
REQ-019 stall_req_o = 1 combinationally when (IDLE and ce_i) or WAIT; 0 in RESP.
REQ-020 Latency: request first seen at edge N gives ack_o=1 in the cycle after edge N+WAIT_CYCLES; back-to-back requests are spaced WAIT_CYCLES+2 cycles.
REQ-021 Write commits on the edge entering RESP, only for lanes with sel_i bit 1; unselected lanes keep their value.
REQ-022 Read returns the full stored word on data_o in RESP regardless of sel; data_o=0 outside RESP.
REQ-023 Word index = addr[DEPTH_LOG2+1:2]; higher address bits ignored (aliasing wrap-around).
REQ-024 A read in RESP of a word written by the immediately preceding access returns the new data.
REQ-025 sel_i=0000 with ce_i=1 completes the full handshake and changes no storage.

Reset
REQ-026 rst low: state IDLE, counter 0, ack_o=0, stall_req_o=0, err_o=0, data_o=0, latched request cleared.
REQ-027 Reset during WAIT discards the pending write; storage contents are not reset.

Configuration
REQ-028 Macro DMEM_ALIGN_CHK_EN defined: in RESP, err_o=1 when (sel=1111 and addr[1:0]!=0) or (sel in {0011,1100} and addr[0]=1); the write is suppressed and data_o=0.
REQ-029 Macro DMEM_ALIGN_CHK_EN undefined: err_o is tied 0 and addr[1:0] is ignored.

Structure
REQ-030 Shared defines file holds the FSM state encodings (DMEM_IDLE/WAIT/RESP) alongside the existing RegBus, ChipEnable and WriteEnable definitions.
REQ-031 Storage is a sub-module dmem_bank: four 8-bit-wide arrays of 2^DEPTH_LOG2 entries with per-lane write enable and a synchronous write port.

Verification
REQ-032 WAIT_CYCLES=2; write addr 0x10, data 0xDEADBEEF, sel 1111, then read 0x10 -> stall_req_o high for 3 cycles on each access, ack_o in cycle 3, read data_o=0xDEADBEEF.
REQ-033 Word 0x20 holds 0x11223344; write sel 0010, data 0x0000AA00 -> read 0x20 returns 0x1122AA44.
REQ-034 Drop ce_i during WAIT of a write of 0xCAFEF00D to 0x30 -> no ack_o; read 0x30 returns the old value.
REQ-035 DEPTH_LOG2=10; write 0x5 to addr 0x1004 -> read addr 0x4 returns 0x5 (alias).
REQ-036 DMEM_ALIGN_CHK_EN defined; write sel 1111 to addr 0x42 -> err_o=1 with ack_o, storage unchanged; undefined -> err_o=0 and word 0x40 written.
REQ-037 rst low mid-WAIT -> all outputs 0 immediately; next request after release completes with normal latency.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: bus widths, enable levels,
// FSM state encodings, the latched request record and the alignment rule.
package dmem_responder_pkg;

    localparam int REG_BUS_W = 32;
    typedef logic [REG_BUS_W-1:0] reg_bus_t;

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic       we;
        logic [3:0] sel;
        reg_bus_t   addr;
        reg_bus_t   data;
    } dmem_req_t;

    // Full-word accesses need a word-aligned address; half-word lane pairs need
    // an even address.
    function automatic logic misaligned(input logic [3:0] sel, input logic [1:0] lo);
        return ((sel == 4'b1111) && (lo != 2'b00)) ||
               (((sel == 4'b0011) || (sel == 4'b1100)) && lo[0]);
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-lane data storage: four 8-bit arrays, per-lane synchronous write, async read.
// Latency: write visible the cycle after the write edge; read is combinational.
// Backpressure: none, the bank accepts a write every cycle.
module dmem_bank #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [3:0]            we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem [2**DEPTH_LOG2];

        // Contents are deliberately not reset; only the control path is.
        always_ff @(posedge clk) begin
            if (we[g]) begin
                mem[waddr] <= wdata[8*g +: 8];
            end
        end

        assign rdata[8*g +: 8] = mem[raddr];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: one access at a time, WAIT_CYCLES wait states.
// Latency: ack_o in the cycle after edge N+WAIT_CYCLES; stalls the pipeline until then.
// Optional macro DMEM_ALIGN_CHK_EN flags and suppresses misaligned accesses via err_o.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        stall_req_o,
    output logic        err_o
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    dmem_state_t state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    dmem_req_t   req_q;
    dmem_req_t   req_in;
    dmem_req_t   commit_req;
    logic        accept;
    logic        entering_resp;
    logic        in_resp;
    logic        commit_misal;
    logic        resp_misal;
    logic [3:0]  bank_we;
    logic [31:0] bank_rdata;
    logic        unused_addr_bits;

    assign req_in = '{we: we_i, sel: sel_i, addr: addr_i, data: data_i};
    assign accept = (state == DMEM_IDLE) && (ce_i == CHIP_ENABLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DMEM_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            DMEM_IDLE: begin
                if (ce_i == CHIP_ENABLE) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = DMEM_RESP;
                        cnt_nxt   = 4'd0;
                    end else begin
                        state_nxt = DMEM_WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end
                end
            end
            DMEM_WAIT: begin
                // A dropped chip enable is a pipeline flush: abandon the access.
                if (ce_i == CHIP_DISABLE) begin
                    state_nxt = DMEM_IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt <= 4'd1) begin
                    state_nxt = DMEM_RESP;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt   = cnt - 4'd1;
                end
            end
            DMEM_RESP: begin
                state_nxt = DMEM_IDLE;
                cnt_nxt   = 4'd0;
            end
            default: begin
                state_nxt = DMEM_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q <= '0;
        end else if (accept) begin
            req_q <= req_in;
        end
    end

    // With zero wait states the write commits on the accept edge itself, so the
    // live inputs are used before they have been latched.
    assign commit_req    = (state == DMEM_IDLE) ? req_in : req_q;
    assign entering_resp = (state != DMEM_RESP) && (state_nxt == DMEM_RESP);
    assign in_resp       = (state == DMEM_RESP);

`ifdef DMEM_ALIGN_CHK_EN
    assign commit_misal = misaligned(commit_req.sel, commit_req.addr[1:0]);
    assign resp_misal   = misaligned(req_q.sel, req_q.addr[1:0]);
`else
    assign commit_misal = 1'b0;
    assign resp_misal   = 1'b0;
`endif

    assign bank_we = (rst && entering_resp && (commit_req.we == WRITE_ENABLE) && !commit_misal)
                   ? commit_req.sel : 4'b0000;

    dmem_bank #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .waddr (commit_req.addr[DEPTH_LOG2+1:2]),
        .wdata (commit_req.data),
        .raddr (req_q.addr[DEPTH_LOG2+1:2]),
        .rdata (bank_rdata)
    );

    assign ack_o       = in_resp;
    assign err_o       = in_resp && resp_misal;
    assign data_o      = (in_resp && (req_q.we == WRITE_DISABLE) && !resp_misal) ? bank_rdata : 32'd0;
    // Gated by reset so every output reads 0 while reset is asserted.
    assign stall_req_o = rst && (accept || (state == DMEM_WAIT));

    // Upper address bits alias onto the storage; low bits only matter to the alignment check.
    assign unused_addr_bits = ^{commit_req.addr, req_q.addr};

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios then random accesses against a word-array model.
module tb_dmem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic        stall_req_o;
    logic        err_o;

    int tests = 0;
    int fails = 0;
    logic [31:0] model_mem [DEPTH];

    dmem_responder #(
        .DEPTH_LOG2  (10),
        .WAIT_CYCLES (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce_i),
        .we_i        (we_i),
        .sel_i       (sel_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .ack_o       (ack_o),
        .stall_req_o (stall_req_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_misaligned(input logic [3:0] sel, input logic [31:0] addr);
`ifdef DMEM_ALIGN_CHK_EN
        return ((sel == 4'b1111) && (addr % 4 != 0)) ||
               (((sel == 4'b0011) || (sel == 4'b1100)) && (addr % 2 != 0));
`else
        return 1'b0;
`endif
    endfunction

    function automatic int word_idx(input logic [31:0] addr);
        return int'((addr / 4) % DEPTH);
    endfunction

    // One complete access from IDLE; checks stall/ack every cycle and the response.
    task automatic access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag);
        logic        err_exp;
        logic [31:0] rd_exp;
        int          idx;
        idx     = word_idx(addr);
        err_exp = exp_misaligned(sel, addr);
        rd_exp  = (we || err_exp) ? 32'd0 : model_mem[idx];
        ce_i = 1'b1; we_i = we; sel_i = sel; addr_i = addr; data_i = wd;
        for (int c = 0; c <= W; c++) begin
            @(negedge clk);
            check({tag, ".stall"}, 32'(stall_req_o), 32'd1);
            check({tag, ".noack"}, 32'(ack_o), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        check({tag, ".ack"}, 32'(ack_o), 32'd1);
        check({tag, ".stall_resp"}, 32'(stall_req_o), 32'd0);
        check({tag, ".err"}, 32'(err_o), 32'(err_exp));
        if (!we) check({tag, ".rdata"}, data_o, rd_exp);
        if (we && !err_exp) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
        end
        @(posedge clk);
        #1 ce_i = 1'b0;
        @(negedge clk);
        check({tag, ".idle_ack"}, 32'(ack_o), 32'd0);
        check({tag, ".idle_stall"}, 32'(stall_req_o), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        logic        w;
        rst = 1'b0; ce_i = 1'b0; we_i = 1'b0; sel_i = 4'd0; addr_i = '0; data_i = '0;
        #1;
        check("rst.ack", 32'(ack_o), 32'd0);
        check("rst.stall", 32'(stall_req_o), 32'd0);
        check("rst.err", 32'(err_o), 32'd0);
        check("rst.data", data_o, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Initialise the 17 words the bench uses so every later read has a known value.
        for (int i = 0; i < 17; i++) access(1'b1, 4'b1111, 32'(i * 4), $urandom, "init");

        access(1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, "wr10");
        access(1'b0, 4'b1111, 32'h10, 32'h0, "rd10");
        check("rd10.model", model_mem[4], 32'hDEADBEEF);

        access(1'b1, 4'b1111, 32'h20, 32'h11223344, "wr20");
        access(1'b1, 4'b0010, 32'h20, 32'h0000AA00, "wr20lane");
        access(1'b0, 4'b0000, 32'h20, 32'h0, "rd20");
        check("rd20.model", model_mem[8], 32'h1122AA44);

        // Abort a write by dropping ce_i in WAIT.
        ce_i = 1'b1; we_i = 1'b1; sel_i = 4'b1111; addr_i = 32'h30; data_i = 32'hCAFEF00D;
        @(posedge clk);
        #1 ce_i = 1'b0;
        @(negedge clk);
        check("abort.noack", 32'(ack_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("abort.idle_ack", 32'(ack_o), 32'd0);
        check("abort.idle_stall", 32'(stall_req_o), 32'd0);
        @(posedge clk);
        #1;
        access(1'b0, 4'b1111, 32'h30, 32'h0, "rd30");

        access(1'b1, 4'b1111, 32'h1004, 32'h5, "wralias");
        access(1'b0, 4'b1111, 32'h4, 32'h0, "rdalias");
        check("rdalias.model", model_mem[1], 32'h5);

        // Word 0x40 written through a misaligned full-word store.
        access(1'b1, 4'b1111, 32'h42, 32'h0BADF00D, "wr42");
        access(1'b0, 4'b1111, 32'h40, 32'h0, "rd40");

        // Reset while a write waits: outputs drop at once, write is discarded.
        ce_i = 1'b1; we_i = 1'b1; sel_i = 4'b1111; addr_i = 32'h8; data_i = 32'h12345678;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rstwait.ack", 32'(ack_o), 32'd0);
        check("rstwait.stall", 32'(stall_req_o), 32'd0);
        check("rstwait.err", 32'(err_o), 32'd0);
        check("rstwait.data", data_o, 32'd0);
        ce_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        access(1'b0, 4'b1111, 32'h8, 32'h0, "rstwait.rd");

        for (int n = 0; n < 60; n++) begin
            w = 1'($urandom);
            s = 4'($urandom);
            a = {$urandom_range(0, 255) * 32'h1000} + 32'($urandom_range(0, 15) * 4)
                + 32'($urandom_range(0, 3));
            d = $urandom;
            access(w, s, a, d, w ? "rnd.wr" : "rnd.rd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
